// File: rtl/regfile_param.sv
// regfile_param: parametrised datapath register file with HI/LO halves,
// a status register and a sequential spill engine for context save.
//
// Ports:
//   clk, rst                clock and synchronous active-high reset
//   rs_addr/rs_data         read port A (combinational, write-through bypass)
//   rt_addr/rt_data         read port B (combinational, write-through bypass)
//   wr_en/wr_addr/wr_data   write port; wr_data[DW] is the ALU carry-out
//   hilo_mode               00 hold, 01 HI+LO, 10 LO only, 11 HI only
//   flag_upd/sr             status load enable / status {Z,N,C,V} in bits 3:0
//   hi, lo                  half-word registers (zero-extended)
//   spill_*                 register stream to data RAM over valid/ready
//
// Spill FSM states:
//   state  | meaning
//   S_IDLE | waiting for spill_start
//   S_SEND | presenting beat idx, waiting for spill_ready
//   S_DONE | last beat accepted, spill_done pulse
module regfile_param #(
   parameter int DW   = 16,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW:0]   wr_data,
   input  logic [1:0]    hilo_mode,
   input  logic          flag_upd,
   output logic [15:0]   sr,
   output logic [DW-1:0] hi,
   output logic [DW-1:0] lo,
   input  logic          spill_start,
   output logic          spill_busy,
   output logic          spill_valid,
   input  logic          spill_ready,
   output logic [AW-1:0] spill_addr,
   output logic [DW-1:0] spill_data,
   output logic          spill_done
);

   localparam int H = DW / 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } spill_state_t;

   logic [DW-1:0] r [NREG];

   spill_state_t  state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          spill_ld;
   logic [AW-1:0] spill_rd_addr;
   logic [DW-1:0] spill_rd_val;

   // Read ports: out-of-range addresses read 0, otherwise a same-cycle
   // write to the addressed register is forwarded.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (int'(rs_addr) < NREG)
         rs_data = (wr_en && wr_addr == rs_addr) ? wr_data[DW-1:0] : r[rs_addr];
      if (int'(rt_addr) < NREG)
         rt_data = (wr_en && wr_addr == rt_addr) ? wr_data[DW-1:0] : r[rt_addr];
   end

   // Register the engine will capture next: r[0] when starting, r[idx+1]
   // on a transfer. The bypass makes a same-edge write land in the beat.
   always_comb begin
      spill_rd_addr = (state_q == S_IDLE) ? '0 : idx_q + AW'(1);
      spill_rd_val  = '0;
      if (int'(spill_rd_addr) < NREG)
         spill_rd_val = (wr_en && wr_addr == spill_rd_addr) ? wr_data[DW-1:0]
                                                             : r[spill_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r[i] <= DW'(i);
      end else if (wr_en && int'(wr_addr) < NREG) begin
         r[wr_addr] <= wr_data[DW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
         sr <= '0;
      end else begin
         if (hilo_mode == 2'b01 || hilo_mode == 2'b11)
            hi <= {{(DW-H){1'b0}}, wr_data[DW-1:H]};
         if (hilo_mode == 2'b01 || hilo_mode == 2'b10)
            lo <= {{(DW-H){1'b0}}, wr_data[H-1:0]};
         if (flag_upd)
            sr <= {12'b0, (rs_data == rt_data), (rt_data > rs_data),
                   wr_data[DW], wr_data[DW]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         spill_data <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (spill_ld) spill_data <= spill_rd_val;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      spill_ld    = 1'b0;
      spill_valid = 1'b0;
      spill_busy  = 1'b0;
      spill_done  = 1'b0;
      spill_addr  = '0;
      case (state_q)
         S_IDLE: begin
            if (spill_start) begin
               state_d  = S_SEND;
               idx_d    = '0;
               spill_ld = 1'b1;
            end
         end
         S_SEND: begin
            spill_valid = 1'b1;
            spill_busy  = 1'b1;
            spill_addr  = idx_q;
            if (spill_ready) begin
               if (int'(idx_q) == NREG - 1) begin
                  state_d = S_DONE;
               end else begin
                  idx_d    = idx_q + AW'(1);
                  spill_ld = 1'b1;
               end
            end
         end
         S_DONE: begin
            spill_busy = 1'b1;
            spill_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;
   localparam int DW   = 16;
   localparam int NREG = 8;
   localparam int AW   = 3;
   localparam int H    = DW / 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs_addr, rt_addr;
   logic [DW-1:0] rs_data, rt_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW:0]   wr_data;
   logic [1:0]    hilo_mode;
   logic          flag_upd;
   logic [15:0]   sr;
   logic [DW-1:0] hi, lo;
   logic          spill_start, spill_busy, spill_valid, spill_ready, spill_done;
   logic [AW-1:0] spill_addr;
   logic [DW-1:0] spill_data;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [DW-1:0] m_r [NREG];
   logic [DW-1:0] m_hi, m_lo;
   logic [15:0]   m_sr;

   always #5 clk = ~clk;

   regfile_param #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .hilo_mode(hilo_mode), .flag_upd(flag_upd), .sr(sr), .hi(hi), .lo(lo),
      .spill_start(spill_start), .spill_busy(spill_busy), .spill_valid(spill_valid),
      .spill_ready(spill_ready), .spill_addr(spill_addr), .spill_data(spill_data),
      .spill_done(spill_done)
   );

   // A read sees the value being written this cycle, else the stored value.
   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      if (int'(a) >= NREG) return '0;
      if (wr_en && wr_addr == a) return wr_data[DW-1:0];
      return m_r[a];
   endfunction

   task automatic model_edge();
      logic [DW-1:0] a, b;
      int wv;
      if (rst) begin
         for (int i = 0; i < NREG; i++) m_r[i] = DW'(i);
         m_hi = '0; m_lo = '0; m_sr = '0;
      end else begin
         a  = model_read(rs_addr);
         b  = model_read(rt_addr);
         wv = int'(wr_data[DW-1:0]);
         if (flag_upd) m_sr = {12'b0, a == b, b > a, wr_data[DW], wr_data[DW]};
         if (hilo_mode == 2'd1 || hilo_mode == 2'd3) m_hi = DW'(wv / (1 << H));
         if (hilo_mode == 2'd1 || hilo_mode == 2'd2) m_lo = DW'(wv % (1 << H));
         if (wr_en && int'(wr_addr) < NREG) m_r[wr_addr] = wr_data[DW-1:0];
      end
   endtask

   // Inputs change at the falling edge; the model follows every rising edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; hilo_mode = 2'd0; flag_upd = 1'b0;
      spill_start = 1'b0; spill_ready = 1'b0; wr_data = '0; wr_addr = '0;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
      checks++; if (sr !== '0) begin failures++; $display("FAIL reset_sr got=%h exp=0", sr); end
      checks++; if ({spill_valid, spill_busy, spill_done} !== 3'b000) begin
         failures++; $display("FAIL reset_spill_ctl got=%b exp=000", {spill_valid, spill_busy, spill_done}); end
      checks++; if (spill_addr !== '0 || spill_data !== '0) begin
         failures++; $display("FAIL reset_spill_beat got=%h/%h exp=0/0", spill_addr, spill_data); end
      for (int i = 0; i < NREG; i++) begin
         rs_addr = AW'(i); rt_addr = AW'(NREG - 1 - i);
         #1;
         checks++; if (rs_data !== DW'(i)) begin
            failures++; $display("FAIL reset_rs[%0d] got=%h exp=%h", i, rs_data, DW'(i)); end
         checks++; if (rt_data !== DW'(NREG - 1 - i)) begin
            failures++; $display("FAIL reset_rt[%0d] got=%h exp=%h", NREG - 1 - i, rt_data, DW'(NREG - 1 - i)); end
      end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 17'h01234; rs_addr = 3'd5; rt_addr = 3'd4;
      #1;
      checks++; if (rs_data !== 16'h1234) begin failures++; $display("FAIL bypass_rs got=%h exp=1234", rs_data); end
      checks++; if (rt_data !== m_r[4]) begin failures++; $display("FAIL bypass_rt got=%h exp=%h", rt_data, m_r[4]); end
      tick();
      wr_en = 1'b0; wr_data = '0;
      #1;
      checks++; if (rs_data !== 16'h1234) begin failures++; $display("FAIL written_r5 got=%h exp=1234", rs_data); end
   endtask

   task automatic test_hilo();
      wr_en = 1'b0; hilo_mode = 2'd1; wr_data = 17'h0ABCD;
      tick();
      checks++; if (hi !== 16'h00AB) begin failures++; $display("FAIL hilo01_hi got=%h exp=00ab", hi); end
      checks++; if (lo !== 16'h00CD) begin failures++; $display("FAIL hilo01_lo got=%h exp=00cd", lo); end
      hilo_mode = 2'd2; wr_data = 17'h01122;
      tick();
      checks++; if (lo !== 16'h0022) begin failures++; $display("FAIL hilo10_lo got=%h exp=0022", lo); end
      checks++; if (hi !== 16'h00AB) begin failures++; $display("FAIL hilo10_hi got=%h exp=00ab", hi); end
      hilo_mode = 2'd3; wr_data = 17'h05566;
      tick();
      checks++; if (hi !== 16'h0055 || lo !== 16'h0022) begin
         failures++; $display("FAIL hilo11 got=%h/%h exp=0055/0022", hi, lo); end
      hilo_mode = 2'd0; wr_data = 17'h1FFFF;
      tick();
      checks++; if (hi !== 16'h0055 || lo !== 16'h0022) begin
         failures++; $display("FAIL hilo00_hold got=%h/%h exp=0055/0022", hi, lo); end
      hilo_mode = 2'd1; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 17'h07788;
      tick();
      wr_en = 1'b0; hilo_mode = 2'd0; rs_addr = 3'd6;
      #1;
      checks++; if (hi !== 16'h0077 || lo !== 16'h0088 || rs_data !== 16'h7788) begin
         failures++; $display("FAIL hilo_with_write got=%h/%h/%h exp=0077/0088/7788", hi, lo, rs_data); end
   endtask

   task automatic test_status();
      wr_en = 1'b0; hilo_mode = 2'd0; rs_addr = 3'd3; rt_addr = 3'd3; wr_data = '0; flag_upd = 1'b1;
      tick();
      checks++; if (sr !== 16'h0008) begin failures++; $display("FAIL sr_equal got=%h exp=0008", sr); end
      flag_upd = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 17'h00001; tick();
      wr_addr = 3'd2; wr_data = 17'h00002; tick();
      wr_en = 1'b0; rs_addr = 3'd1; rt_addr = 3'd2; wr_data = 17'h10000; flag_upd = 1'b1;
      tick();
      checks++; if (sr !== 16'h0007) begin failures++; $display("FAIL sr_less_carry got=%h exp=0007", sr); end
      flag_upd = 1'b0; rs_addr = 3'd3; wr_data = '0;
      tick();
      checks++; if (sr !== 16'h0007) begin failures++; $display("FAIL sr_hold got=%h exp=0007", sr); end
   endtask

   task automatic test_random();
      logic [DW-1:0] e_rs, e_rt;
      for (int n = 0; n < 300; n++) begin
         wr_en     = 1'($urandom);
         wr_addr   = AW'($urandom);
         wr_data   = (DW+1)'($urandom);
         hilo_mode = 2'($urandom);
         flag_upd  = 1'($urandom);
         rs_addr   = AW'($urandom);
         rt_addr   = ($urandom_range(0, 3) == 0) ? rs_addr : AW'($urandom);
         if ($urandom_range(0, 3) == 0) rs_addr = wr_addr;
         #1;
         e_rs = model_read(rs_addr);
         e_rt = model_read(rt_addr);
         checks++; if (rs_data !== e_rs) begin failures++; $display("FAIL rand_rs n=%0d got=%h exp=%h", n, rs_data, e_rs); end
         checks++; if (rt_data !== e_rt) begin failures++; $display("FAIL rand_rt n=%0d got=%h exp=%h", n, rt_data, e_rt); end
         tick();
         checks++; if (hi !== m_hi || lo !== m_lo) begin
            failures++; $display("FAIL rand_hilo n=%0d got=%h/%h exp=%h/%h", n, hi, lo, m_hi, m_lo); end
         checks++; if (sr !== m_sr) begin failures++; $display("FAIL rand_sr n=%0d got=%h exp=%h", n, sr, m_sr); end
      end
      wr_en = 1'b0; hilo_mode = 2'd0; flag_upd = 1'b0;
   endtask

   // mode 0: ready held high (after reset, beats carry 0..NREG-1)
   // mode 1: stall on beat 2 with writes to r2 during the stall and r3 at accept
   // mode 2: random ready, writes, reads and ignored starts
   // mode 3: reset asserted while beat 4 is presented
   task automatic test_spill(input int mode);
      int k, cyc;
      int stalls;
      logic [DW-1:0] exp_d, e_rs;
      logic acc;
      wr_en = 1'b0; flag_upd = 1'b0; hilo_mode = 2'd0; spill_ready = 1'b0; spill_start = 1'b1;
      tick();
      spill_start = 1'b0;
      exp_d = m_r[0]; k = 0; cyc = 0; stalls = 0;
      while (k < NREG && cyc < 500) begin
         wr_en = 1'b0; spill_ready = 1'b1; spill_start = 1'b0;
         if (mode == 1 && k == 2) begin
            if (stalls < 3) begin
               spill_ready = 1'b0;
               if (stalls == 0) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 17'h0FFFF; end
            end else begin
               wr_en = 1'b1; wr_addr = 3'd3; wr_data = 17'h0EEEE;
            end
         end else if (mode == 2) begin
            spill_ready = 1'($urandom);
            spill_start = 1'($urandom);
            wr_en       = 1'($urandom);
            wr_addr     = AW'($urandom);
            wr_data     = (DW+1)'($urandom);
            rs_addr     = AW'($urandom);
         end
         #1;
         checks++; if (spill_valid !== 1'b1 || spill_busy !== 1'b1 || spill_done !== 1'b0) begin
            failures++; $display("FAIL spill_ctl m=%0d k=%0d got=%b exp=110", mode, k, {spill_valid, spill_busy, spill_done}); end
         checks++; if (spill_addr !== AW'(k)) begin
            failures++; $display("FAIL spill_addr m=%0d got=%0d exp=%0d", mode, spill_addr, k); end
         checks++; if (spill_data !== exp_d) begin
            failures++; $display("FAIL spill_data m=%0d k=%0d got=%h exp=%h", mode, k, spill_data, exp_d); end
         if (mode == 0) begin
            checks++; if (spill_data !== DW'(k)) begin
               failures++; $display("FAIL spill_idx_val k=%0d got=%h exp=%h", k, spill_data, DW'(k)); end
         end
         if (mode == 1 && k == 2) begin
            checks++; if (spill_data !== 16'h0002) begin
               failures++; $display("FAIL spill_stall_b2 got=%h exp=0002", spill_data); end
         end
         if (mode == 1 && k == 3) begin
            checks++; if (spill_data !== 16'hEEEE) begin
               failures++; $display("FAIL spill_capture_b3 got=%h exp=eeee", spill_data); end
         end
         if (mode == 2) begin
            e_rs = model_read(rs_addr);
            checks++; if (rs_data !== e_rs) begin
               failures++; $display("FAIL spill_concurrent_rs got=%h exp=%h", rs_data, e_rs); end
         end
         if (mode == 3 && k == 4) begin
            rst = 1'b1; wr_en = 1'b0;
            tick();
            rst = 1'b0;
            #1;
            checks++; if ({spill_valid, spill_busy, spill_done} !== 3'b000) begin
               failures++; $display("FAIL abort_ctl got=%b exp=000", {spill_valid, spill_busy, spill_done}); end
            checks++; if (spill_addr !== '0 || spill_data !== '0) begin
               failures++; $display("FAIL abort_beat got=%h/%h exp=0/0", spill_addr, spill_data); end
            for (int i = 0; i < NREG; i++) begin
               rs_addr = AW'(i);
               #1;
               checks++; if (rs_data !== DW'(i)) begin
                  failures++; $display("FAIL abort_reg[%0d] got=%h exp=%h", i, rs_data, DW'(i)); end
            end
            tick();
            checks++; if (spill_valid !== 1'b0 || spill_busy !== 1'b0) begin
               failures++; $display("FAIL abort_stays_idle got=%b exp=00", {spill_valid, spill_busy}); end
            return;
         end
         acc = spill_ready;
         tick();
         cyc++;
         if (acc) begin
            k++;
            if (k < NREG) exp_d = m_r[k];
         end else begin
            stalls++;
         end
      end
      wr_en = 1'b0; spill_start = 1'b0; spill_ready = 1'b1;
      checks++; if (k !== NREG) begin
         failures++; $display("FAIL spill_timeout m=%0d got=%0d exp=%0d", mode, k, NREG); end
      if (mode == 0) begin
         checks++; if (cyc !== NREG) begin
            failures++; $display("FAIL spill_latency got=%0d exp=%0d", cyc, NREG); end
      end
      #1;
      checks++; if ({spill_valid, spill_busy, spill_done} !== 3'b011) begin
         failures++; $display("FAIL spill_done_pulse m=%0d got=%b exp=011", mode, {spill_valid, spill_busy, spill_done}); end
      spill_start = (mode == 2);
      tick();
      spill_start = 1'b0;
      checks++; if ({spill_valid, spill_busy, spill_done} !== 3'b000) begin
         failures++; $display("FAIL spill_end m=%0d got=%b exp=000", mode, {spill_valid, spill_busy, spill_done}); end
   endtask

   initial begin
      rst = 1'b1; rs_addr = '0; rt_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      hilo_mode = 2'd0; flag_upd = 1'b0; spill_start = 1'b0; spill_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_bypass();
      test_hilo();
      test_status();
      test_random();
      test_reset();
      test_spill(0);
      test_spill(1);
      test_spill(2);
      test_reset();
      test_spill(3);
      test_spill(0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the datapath register file. It provides:
- NREG general registers of DW bits, with two combinational read ports and one write port with same-cycle write-through bypass.
- HI/LO half-word registers.
- A registered status register (Z/N/C/V).
- A sequential spill engine that streams every register to data RAM over a valid/ready handshake, for context save.

Parameters:
DW, 16, data width in bits; must be even.
NREG, 8, number of general registers; must be ≥2.
AW, 3, register address width; must satisfy 2^AW ≥ NREG.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
rs_addr  in  AW  read port A address
rt_addr  in  AW  read port B address
rs_data  out  DW  read port A data (combinational)
rt_data  out  DW  read port B data (combinational)
wr_en  in  1  general-register write enable
wr_addr  in  AW  write address
wr_data  in  DW+1  write data; bit DW is the ALU carry-out
hilo_mode  in  2  00 none, 01 write HI+LO, 10 LO only, 11 HI only
flag_upd  in  1  load status register this cycle
sr  out  16  status register: bit3 Z, bit2 N, bit1 C, bit0 V, others 0
hi  out  DW  HI register
lo  out  DW  LO register
spill_start  in  1  request a full register spill
spill_busy  out  1  spill engine active
spill_valid  out  1  spill beat valid
spill_ready  in  1  RAM accepts beat
spill_addr  out  AW  register index of the current beat
spill_data  out  DW  register contents of the current beat
spill_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (rst=1 at clk edge), with priority over all other inputs:
  - r[i] <= i for all i; hi, lo, sr <= 0.
  - Spill FSM goes to IDLE; spill_valid, spill_busy, spill_done, spill_addr and spill_data are all 0 from the next cycle.
  - Reset mid-spill aborts the spill; no further beats are issued.
- Read ports:
  - rs_data = (wr_en && wr_addr==rs_addr) ? wr_data[DW-1:0] : r[rs_addr]. rt_data follows the same rule.
  - Addresses ≥ NREG read 0.
- Write: when wr_en=1, r[wr_addr] <= wr_data[DW-1:0] at the edge. Addresses ≥ NREG are ignored. r[0] is writable.
- HI/LO, independent of wr_en; H = DW/2:
  - 01: hi <= {0, wr_data[DW-1:H]} and lo <= {0, wr_data[H-1:0]}.
  - 10: lo only is updated, as above.
  - 11: hi only is updated, as above.
  - 00: both hold.
- Status register, loaded only when flag_upd=1, otherwise held. All fields are evaluated on the bypassed port values:
  - Z = (rs_data==rt_data).
  - N = (rt_data > rs_data), unsigned compare.
  - C = wr_data[DW].
  - V = wr_data[DW].
- Spill FSM, states IDLE, SEND, DONE:
  - IDLE: spill_start=1 → SEND. idx <= 0, and spill_data is loaded with the bypassed value of r[0].
  - SEND: spill_valid=1, spill_addr=idx. spill_data is a register and stays stable while spill_ready=0.
  - SEND, on a transfer (valid && ready):
    - If idx == NREG-1 → DONE.
    - Otherwise idx <= idx+1, and spill_data is loaded with the bypassed value of r[idx+1] (a same-edge write to idx+1 is captured).
  - DONE: spill_done=1 for exactly one cycle → IDLE.
  - spill_busy = 1 in SEND and DONE. spill_start is ignored while busy.
  - Writes to already-sent or currently-presented registers during SEND do not alter or resend beats.
  - Minimum spill latency is NREG+1 cycles from start to done with ready held high.
- Simultaneous events: wr_en and hilo_mode may act in the same cycle; both take effect. A spill runs concurrently with normal reads and writes.

Test Plan:
- Reset then read all ports → rs_data = index (r[5]=5). Drive wr_en=1, wr_addr=5, wr_data=0x1234 with rs_addr=5 → rs_data=0x1234 in the same cycle, and r[5]=0x1234 after the edge.
- hilo_mode=01 with wr_data=0xABCD → hi=0x00AB, lo=0x00CD. Then mode 10 with 0x1122 → lo=0x0022, hi unchanged at 0x00AB.
- rs=rt=3 with flag_upd=1 → sr=0x0008. Then r1=1, r2=2, rs_addr=1, rt_addr=2, wr_data[16]=1 → sr=0x0007.
- spill_start with spill_ready tied to 1 → beats with spill_addr 0..7 and spill_data 0..7 on consecutive cycles, then spill_done one cycle later, then busy drops.
- Spill with spill_ready low for 3 cycles on beat 2, and a write of 0xFFFF to r[2] during the stall → beat 2 still carries 2. A write of 0xEEEE to r[3] at the edge where beat 2 is accepted → beat 3 carries 0xEEEE.
- rst asserted during beat 4 → next cycle spill_valid=0, busy=0, registers back to index values. A new spill_start then restarts from beat 0.
